// File: rtl/vga_scan_engine_if.sv
// Framebuffer read port: the scan engine is the master, the pixel-domain BRAM/read mux the slave.
interface vga_scan_engine_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/vga_scan_engine.sv
// Raster engine: h/v counters, centred and upscaled framebuffer address generation,
// and a latency-matched sync/DE/RGB output stage.
module vga_scan_engine #(
    parameter int          W_VIS      = 640,
    parameter int          H_VIS      = 480,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          W_FB       = 320,
    parameter int          H_FB       = 240,
    parameter int          SCALE      = 2,
    parameter int          ADDR_W     = 17,
    parameter int          DATA_W     = 16,
    parameter int          RD_LAT     = 1,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter logic [11:0] BORDER_RGB = 12'h000
) (
    input  logic              pix_clk,
    input  logic              prst,
    vga_scan_engine_if.master fb,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_de,
    output logic [11:0]       vga_rgb,
    output logic              vblank_start,
    output logic              frame_toggle
);
    localparam int H_TOT    = W_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = H_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOT);
    localparam int VW       = $clog2(V_TOT);
    localparam int HX       = HW + 1;
    localparam int VX       = VW + 1;
    localparam int IMG_W    = W_FB * SCALE;
    localparam int IMG_H    = H_FB * SCALE;
    localparam int X_OFF    = (W_VIS - IMG_W) / 2;
    localparam int Y_OFF    = (H_VIS - IMG_H) / 2;
    localparam int HS_START = W_VIS + H_FP;
    localparam int VS_START = H_VIS + V_FP;
    localparam int LAT      = RD_LAT + 2;
    localparam int DEPTH    = LAT - 1;
    localparam int SW       = (SCALE > 1) ? $clog2(SCALE) : 1;

    if (IMG_W > W_VIS || IMG_H > H_VIS ||
        longint'(W_FB) * longint'(H_FB) > (longint'(1) << ADDR_W) ||
        SCALE < 1 || SCALE > 8 || RD_LAT < 1 || RD_LAT > 3 || DATA_W < 12) begin : g_bad_params
        $error("vga_scan_engine: illegal parameter combination");
    end

    if (DATA_W > 12) begin : g_unused_data
        logic unused_rd_bits;
        assign unused_rd_bits = ^fb.rd_data[DATA_W-1:12];
    end

    logic [HW-1:0]     h_reg;
    logic [VW-1:0]     v_reg;
    logic [ADDR_W-1:0] col_reg;
    logic [ADDR_W-1:0] row_base_reg;
    logic [SW-1:0]     col_sub_reg;
    logic [SW-1:0]     row_sub_reg;
    logic              rd_en_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              vblank_start_reg;
    logic              frame_toggle_reg;

    logic [HX-1:0] h_x;
    logic [VX-1:0] v_x;
    logic          h_last;
    logic          v_last;
    logic          in_x;
    logic          in_y;
    logic          in_img;
    logic          vis;
    logic          hs_act;
    logic          vs_act;
    logic          vblank_hit;
    logic          col_sub_last;
    logic          row_sub_last;

    assign h_x    = {1'b0, h_reg};
    assign v_x    = {1'b0, v_reg};
    assign h_last = (h_reg == HW'(H_TOT - 1));
    assign v_last = (v_reg == VW'(V_TOT - 1));

    // Offset-and-compare windows: the subtraction wraps to a large value below the start,
    // so a single unsigned compare covers both bounds.
    assign in_x   = (h_x - HX'(X_OFF)) < HX'(IMG_W);
    assign in_y   = (v_x - VX'(Y_OFF)) < VX'(IMG_H);
    assign in_img = in_x && in_y;
    assign vis    = (h_x < HX'(W_VIS)) && (v_x < VX'(H_VIS));
    assign hs_act = (h_x - HX'(HS_START)) < HX'(H_SYNC);
    assign vs_act = (v_x - VX'(VS_START)) < VX'(V_SYNC);

    assign vblank_hit   = (h_reg == '0) && (v_reg == VW'(H_VIS));
    assign col_sub_last = (col_sub_reg == SW'(SCALE - 1));
    assign row_sub_last = (row_sub_reg == SW'(SCALE - 1));

    // Raster counters
    always_ff @(posedge pix_clk) begin
        if (prst) begin
            h_reg <= '0;
            v_reg <= '0;
        end else begin
            h_reg <= h_last ? '0 : h_reg + HW'(1);
            if (h_last) begin
                v_reg <= v_last ? '0 : v_reg + VW'(1);
            end
        end
    end

    // Column index steps every SCALE pixels inside the window and is cleared outside it.
    always_ff @(posedge pix_clk) begin
        if (prst) begin
            col_reg     <= '0;
            col_sub_reg <= '0;
        end else if (in_x) begin
            if (col_sub_last) begin
                col_sub_reg <= '0;
                col_reg     <= col_reg + ADDR_W'(1);
            end else begin
                col_sub_reg <= col_sub_reg + SW'(1);
            end
        end else begin
            col_reg     <= '0;
            col_sub_reg <= '0;
        end
    end

    // Row base steps by one framebuffer line every SCALE window lines; rewinds at frame wrap.
    always_ff @(posedge pix_clk) begin
        if (prst) begin
            row_base_reg <= '0;
            row_sub_reg  <= '0;
        end else if (h_last) begin
            if (v_last) begin
                row_base_reg <= '0;
                row_sub_reg  <= '0;
            end else if (in_y) begin
                if (row_sub_last) begin
                    row_sub_reg  <= '0;
                    row_base_reg <= row_base_reg + ADDR_W'(W_FB);
                end else begin
                    row_sub_reg <= row_sub_reg + SW'(1);
                end
            end
        end
    end

    // Read request stage; the address holds its last value outside the window.
    always_ff @(posedge pix_clk) begin
        if (prst) begin
            rd_en_reg   <= 1'b0;
            rd_addr_reg <= '0;
        end else begin
            rd_en_reg <= in_img;
            if (in_img) begin
                rd_addr_reg <= row_base_reg + col_reg;
            end
        end
    end

    assign fb.rd_en   = rd_en_reg;
    assign fb.rd_addr = rd_addr_reg;

    // Frame event taken straight from the counters, ahead of the video pipeline.
    always_ff @(posedge pix_clk) begin
        if (prst) begin
            vblank_start_reg <= 1'b0;
            frame_toggle_reg <= 1'b0;
        end else begin
            vblank_start_reg <= vblank_hit;
            if (vblank_hit) begin
                frame_toggle_reg <= ~frame_toggle_reg;
            end
        end
    end

    assign vblank_start = vblank_start_reg;
    assign frame_toggle = frame_toggle_reg;

    // Control delay line: {vis, in_img, hs_act, vs_act}. Its tail lines up with rd_data.
    logic [DEPTH-1:0][3:0] pipe_reg;
    logic [3:0]            tail;

    always_ff @(posedge pix_clk) begin
        if (prst) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg <= {pipe_reg[DEPTH-2:0], {vis, in_img, hs_act, vs_act}};
        end
    end

    assign tail = pipe_reg[DEPTH-1];

    logic        vga_hsync_reg;
    logic        vga_vsync_reg;
    logic        vga_de_reg;
    logic [11:0] vga_rgb_reg;

    always_ff @(posedge pix_clk) begin
        if (prst) begin
            vga_hsync_reg <= ~HS_POL;
            vga_vsync_reg <= ~VS_POL;
            vga_de_reg    <= 1'b0;
            vga_rgb_reg   <= '0;
        end else begin
            vga_hsync_reg <= tail[1] ? HS_POL : ~HS_POL;
            vga_vsync_reg <= tail[0] ? VS_POL : ~VS_POL;
            vga_de_reg    <= tail[3];
            if (tail[2]) begin
                vga_rgb_reg <= fb.rd_data[11:0];
            end else if (tail[3]) begin
                vga_rgb_reg <= BORDER_RGB;
            end else begin
                vga_rgb_reg <= '0;
            end
        end
    end

    assign vga_hsync = vga_hsync_reg;
    assign vga_vsync = vga_vsync_reg;
    assign vga_de    = vga_de_reg;
    assign vga_rgb   = vga_rgb_reg;
endmodule

// File: tb/tb_vga_scan_engine.sv
// Bench for vga_scan_engine on a shrunken raster: closed-form position model, random
// framebuffer contents and random reset pulses.
module tb_vga_scan_engine;
    localparam int          W_VIS  = 40;
    localparam int          H_VIS  = 30;
    localparam int          H_FP   = 4;
    localparam int          H_SYNC = 6;
    localparam int          H_BP   = 5;
    localparam int          V_FP   = 2;
    localparam int          V_SYNC = 3;
    localparam int          V_BP   = 2;
    localparam int          W_FB   = 12;
    localparam int          H_FB   = 9;
    localparam int          SCALE  = 3;
    localparam int          ADDR_W = 8;
    localparam int          DATA_W = 16;
    localparam int          RD_LAT = 3;
    localparam bit          HS_POL = 1'b1;
    localparam bit          VS_POL = 1'b0;
    localparam logic [11:0] BORDER = 12'hF00;

    localparam int H_TOT = W_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = H_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int X_OFF = (W_VIS - W_FB * SCALE) / 2;
    localparam int Y_OFF = (H_VIS - H_FB * SCALE) / 2;
    localparam int LAT   = RD_LAT + 2;

    logic        clk  = 1'b0;
    logic        prst = 1'b1;
    logic        vga_hsync, vga_vsync, vga_de, vblank_start, frame_toggle;
    logic [11:0] vga_rgb;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    vga_scan_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) fbi ();

    vga_scan_engine #(
        .W_VIS(W_VIS), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .W_FB(W_FB), .H_FB(H_FB),
        .SCALE(SCALE), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .BORDER_RGB(BORDER)
    ) dut (
        .pix_clk(clk), .prst(prst), .fb(fbi),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
        .vga_rgb(vga_rgb), .vblank_start(vblank_start), .frame_toggle(frame_toggle)
    );

    // Framebuffer with RD_LAT-cycle read latency
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] bq  [RD_LAT];
    always @(posedge clk) begin
        bq[0] <= fbi.rd_en ? mem[fbi.rd_addr] : 16'hBEEF;
        for (int i = 1; i < RD_LAT; i++) bq[i] <= bq[i-1];
    end
    assign fbi.rd_data = bq[RD_LAT-1];

    // Model state: n = clock edges since reset release, i.e. the raster position now shown by the counters.
    int n      = 0;
    int m_addr = 0;
    bit m_rd_en, m_vbs, m_tog;

    function automatic bit in_win(input int p);
        int h = p % H_TOT;
        int v = (p / H_TOT) % V_TOT;
        return (h >= X_OFF) && (h < X_OFF + W_FB * SCALE) && (v >= Y_OFF) && (v < Y_OFF + H_FB * SCALE);
    endfunction

    function automatic int addr_of(input int p);
        int h = p % H_TOT;
        int v = (p / H_TOT) % V_TOT;
        return ((v - Y_OFF) / SCALE) * W_FB + (h - X_OFF) / SCALE;
    endfunction

    task automatic advance();
        @(posedge clk);
        if (prst) begin
            n = 0; m_rd_en = 0; m_addr = 0; m_vbs = 0; m_tog = 0;
        end else begin
            m_rd_en = in_win(n);
            if (m_rd_en) m_addr = addr_of(n);
            m_vbs = ((n % FRAME) == H_VIS * H_TOT);
            if (m_vbs) m_tog = !m_tog;
            n++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            advance();
            checks += 8;
            if (vga_hsync !== !HS_POL) begin errors++; $display("FAIL reset_hsync: got %b want %b", vga_hsync, !HS_POL); end
            if (vga_vsync !== !VS_POL) begin errors++; $display("FAIL reset_vsync: got %b want %b", vga_vsync, !VS_POL); end
            if (vga_de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b want 0", vga_de); end
            if (vga_rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h want 000", vga_rgb); end
            if (fbi.rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", fbi.rd_en); end
            if (fbi.rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %h want 0", fbi.rd_addr); end
            if (vblank_start !== 1'b0) begin errors++; $display("FAIL reset_vblank: got %b want 0", vblank_start); end
            if (frame_toggle !== 1'b0) begin errors++; $display("FAIL reset_toggle: got %b want 0", frame_toggle); end
        end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_raster(input int cycles);
        int p, h, v;
        bit e_de, e_hs, e_vs;
        logic [11:0] e_rgb;
        logic [DATA_W-1:0] word;
        for (int c = 0; c < cycles; c++) begin
            advance();
            if (n < LAT) begin
                e_de = 0; e_hs = !HS_POL; e_vs = !VS_POL; e_rgb = 12'h000;
            end else begin
                p = n - LAT;
                h = p % H_TOT;
                v = (p / H_TOT) % V_TOT;
                e_de = (h < W_VIS) && (v < H_VIS);
                e_hs = (h >= W_VIS + H_FP && h < W_VIS + H_FP + H_SYNC) ? HS_POL : !HS_POL;
                e_vs = (v >= H_VIS + V_FP && v < H_VIS + V_FP + V_SYNC) ? VS_POL : !VS_POL;
                if (in_win(p)) begin
                    word  = mem[addr_of(p)];
                    e_rgb = word[11:0];
                end else begin
                    e_rgb = e_de ? BORDER : 12'h000;
                end
            end
            checks += 8;
            if (fbi.rd_en !== m_rd_en) begin errors++; $display("FAIL rd_en n=%0d: got %b want %b", n, fbi.rd_en, m_rd_en); end
            if (fbi.rd_addr !== ADDR_W'(m_addr)) begin errors++; $display("FAIL rd_addr n=%0d: got %0d want %0d", n, fbi.rd_addr, m_addr); end
            if (vga_de !== e_de) begin errors++; $display("FAIL de n=%0d: got %b want %b", n, vga_de, e_de); end
            if (vga_hsync !== e_hs) begin errors++; $display("FAIL hsync n=%0d: got %b want %b", n, vga_hsync, e_hs); end
            if (vga_vsync !== e_vs) begin errors++; $display("FAIL vsync n=%0d: got %b want %b", n, vga_vsync, e_vs); end
            if (vga_rgb !== e_rgb) begin errors++; $display("FAIL rgb n=%0d: got %h want %h", n, vga_rgb, e_rgb); end
            if (vblank_start !== m_vbs) begin errors++; $display("FAIL vblank_start n=%0d: got %b want %b", n, vblank_start, m_vbs); end
            if (frame_toggle !== m_tog) begin errors++; $display("FAIL frame_toggle n=%0d: got %b want %b", n, frame_toggle, m_tog); end
        end
        $display("test_raster %0d cycles done: checks=%0d errors=%0d", cycles, checks, errors);
    endtask

    task automatic test_sync_counts();
        int hs_n = 0, vs_n = 0, de_n = 0, en_n = 0, vb_n = 0, tg_n = 0;
        int hs_run = 0, hs_max = 0, de_run = 0, de_max = 0;
        logic prev_tog;
        prev_tog = frame_toggle;
        for (int c = 0; c < FRAME; c++) begin
            advance();
            if (vga_hsync === HS_POL) begin hs_n++; hs_run++; end else hs_run = 0;
            if (vga_de === 1'b1) begin de_n++; de_run++; end else de_run = 0;
            if (hs_run > hs_max) hs_max = hs_run;
            if (de_run > de_max) de_max = de_run;
            if (vga_vsync === VS_POL) vs_n++;
            if (fbi.rd_en === 1'b1) en_n++;
            if (vblank_start === 1'b1) vb_n++;
            if (frame_toggle !== prev_tog) tg_n++;
            prev_tog = frame_toggle;
        end
        checks += 8;
        if (hs_n != H_SYNC * V_TOT) begin errors++; $display("FAIL hsync_total: got %0d want %0d", hs_n, H_SYNC * V_TOT); end
        if (hs_max != H_SYNC) begin errors++; $display("FAIL hsync_width: got %0d want %0d", hs_max, H_SYNC); end
        if (vs_n != V_SYNC * H_TOT) begin errors++; $display("FAIL vsync_total: got %0d want %0d", vs_n, V_SYNC * H_TOT); end
        if (de_n != W_VIS * H_VIS) begin errors++; $display("FAIL de_total: got %0d want %0d", de_n, W_VIS * H_VIS); end
        if (de_max != W_VIS) begin errors++; $display("FAIL de_width: got %0d want %0d", de_max, W_VIS); end
        if (en_n != W_FB * SCALE * H_FB * SCALE) begin errors++; $display("FAIL rd_en_total: got %0d want %0d", en_n, W_FB * SCALE * H_FB * SCALE); end
        if (vb_n != 1) begin errors++; $display("FAIL vblank_per_frame: got %0d want 1", vb_n); end
        if (tg_n != 1) begin errors++; $display("FAIL toggle_per_frame: got %0d want 1", tg_n); end
        $display("test_sync_counts done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        while ((n % FRAME) != 20 * H_TOT + 30 && guard < 2 * FRAME) begin
            advance();
            guard++;
        end
        prst = 1'b1;
        advance();
        prst = 1'b0;
        checks += 8;
        if (vga_hsync !== !HS_POL) begin errors++; $display("FAIL midrst_hsync: got %b want %b", vga_hsync, !HS_POL); end
        if (vga_vsync !== !VS_POL) begin errors++; $display("FAIL midrst_vsync: got %b want %b", vga_vsync, !VS_POL); end
        if (vga_de !== 1'b0) begin errors++; $display("FAIL midrst_de: got %b want 0", vga_de); end
        if (vga_rgb !== 12'h000) begin errors++; $display("FAIL midrst_rgb: got %h want 000", vga_rgb); end
        if (fbi.rd_en !== 1'b0) begin errors++; $display("FAIL midrst_rd_en: got %b want 0", fbi.rd_en); end
        if (fbi.rd_addr !== '0) begin errors++; $display("FAIL midrst_rd_addr: got %h want 0", fbi.rd_addr); end
        if (vblank_start !== 1'b0) begin errors++; $display("FAIL midrst_vblank: got %b want 0", vblank_start); end
        if (frame_toggle !== 1'b0) begin errors++; $display("FAIL midrst_toggle: got %b want 0", frame_toggle); end
        $display("test_mid_reset done: checks=%0d errors=%0d", checks, errors);
        test_raster(FRAME + 200);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            test_raster(int'($urandom_range(1500, 40)));
            prst = 1'b1;
            test_raster(int'($urandom_range(4, 1)));
            prst = 1'b0;
        end
        test_raster(FRAME);
    endtask

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = DATA_W'($urandom);
        test_reset();
        prst = 1'b0;
        test_raster(3 * FRAME);
        test_sync_counts();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
